// File: rtl/steer_en_datapath.sv
// steer_en_datapath: load-cell front end for the steering-enable state machine.
// Captures left/right load-cell samples, produces registered rider-weight and
// imbalance qualifiers, and owns the settle timer and the sample-staleness watchdog.
module steer_en_datapath #(
  parameter bit          FAST_SIM     = 1'b0,
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] HYSTERESIS   = 12'h040,
  parameter logic [19:0] STALE_CYC    = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        clr_tmr,
  output logic        tmr_full,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16,
  output logic        ld_stale
);

  // Settle-timer terminal count: short in simulation, 1.3 s at 50 MHz otherwise.
  localparam logic [25:0] TERM   = FAST_SIM ? 26'd32767 : 26'd64_999_999;
  // Hysteresis band edges, widened to 13 bits so the sum compares never overflow.
  localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, HYSTERESIS};
  localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT} - {1'b0, HYSTERESIS};

  logic [11:0] lft_r;
  logic [11:0] rght_r;
  logic [19:0] stale_cnt_r;
  logic [25:0] tmr_cnt_r;

  logic [12:0] sum_s;
  logic [11:0] diff_s;
  logic [12:0] diff_ext_s;
  logic [19:0] stale_cnt_nxt_s;
  logic [25:0] tmr_cnt_nxt_s;
  logic        gt_nxt_s;
  logic        lt_nxt_s;
  logic        d14_nxt_s;
  logic        d1516_nxt_s;

  // Sum and absolute difference of the captured samples (larger minus smaller, no wrap).
  always_comb begin
    sum_s  = {1'b0, lft_r} + {1'b0, rght_r};
    diff_s = 12'h000;
    if (lft_r >= rght_r) begin
      diff_s = lft_r - rght_r;
    end else begin
      diff_s = rght_r - lft_r;
    end
    diff_ext_s = {1'b0, diff_s};
  end

  // Qualifier flags; a stale sample reads as "no rider, centred" so the SM backs off.
  always_comb begin
    gt_nxt_s    = 1'b0;
    lt_nxt_s    = 1'b1;
    d14_nxt_s   = 1'b0;
    d1516_nxt_s = 1'b0;
    if (ld_stale) begin
      gt_nxt_s    = 1'b0;
      lt_nxt_s    = 1'b1;
      d14_nxt_s   = 1'b0;
      d1516_nxt_s = 1'b0;
    end else begin
      gt_nxt_s    = (sum_s > THR_HI);
      lt_nxt_s    = (sum_s < THR_LO);
      d14_nxt_s   = (diff_ext_s > (sum_s >> 2));
      d1516_nxt_s = (diff_ext_s > (sum_s - (sum_s >> 4)));
    end
  end

  // Staleness counter: restarts on every valid sample, saturates at STALE_CYC.
  always_comb begin
    stale_cnt_nxt_s = stale_cnt_r;
    if (ld_vld) begin
      stale_cnt_nxt_s = 20'd0;
    end else if (stale_cnt_r < STALE_CYC) begin
      stale_cnt_nxt_s = stale_cnt_r + 20'd1;
    end else begin
      stale_cnt_nxt_s = stale_cnt_r;
    end
  end

  // Settle timer: clear has priority, otherwise count up and hold at terminal count.
  always_comb begin
    tmr_cnt_nxt_s = tmr_cnt_r;
    if (clr_tmr) begin
      tmr_cnt_nxt_s = 26'd0;
    end else if (tmr_cnt_r < TERM) begin
      tmr_cnt_nxt_s = tmr_cnt_r + 26'd1;
    end else begin
      tmr_cnt_nxt_s = tmr_cnt_r;
    end
  end

  // Sample capture registers, loaded only on the valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_r  <= 12'h000;
      rght_r <= 12'h000;
    end else if (ld_vld) begin
      lft_r  <= lft_ld;
      rght_r <= rght_ld;
    end else begin
      lft_r  <= lft_r;
      rght_r <= rght_r;
    end
  end

  // Watchdog and timer state; stale/full flags track the next counter values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale_cnt_r <= 20'd0;
      ld_stale    <= 1'b0;
      tmr_cnt_r   <= 26'd0;
      tmr_full    <= 1'b0;
    end else begin
      stale_cnt_r <= stale_cnt_nxt_s;
      ld_stale    <= (stale_cnt_nxt_s == STALE_CYC);
      tmr_cnt_r   <= tmr_cnt_nxt_s;
      // A clear landing on terminal count keeps tmr_full low.
      tmr_full    <= (!clr_tmr) && (tmr_cnt_r == TERM);
    end
  end

  // Registered qualifier outputs, one edge behind the capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_gt_min    <= 1'b0;
      sum_lt_min    <= 1'b1;
      diff_gt_1_4   <= 1'b0;
      diff_gt_15_16 <= 1'b0;
    end else begin
      sum_gt_min    <= gt_nxt_s;
      sum_lt_min    <= lt_nxt_s;
      diff_gt_1_4   <= d14_nxt_s;
      diff_gt_15_16 <= d1516_nxt_s;
    end
  end

endmodule

// File: tb/tb_steer_en_datapath.sv
// Self-checking bench for steer_en_datapath (FAST_SIM=1, STALE_CYC=100).
// Instance b shares all stimulus except clr_tmr and exercises a clear that
// coincides with terminal count while instance a counts undisturbed.
module tb_steer_en_datapath;

  typedef struct packed {
    logic gt;
    logic lt;
    logic d14;
    logic d1516;
  } flags_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        clr_tmr;
  logic        clr_tmr_b;
  logic        tmr_full, sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, ld_stale;
  logic        tmr_full_b, sum_gt_min_b, sum_lt_min_b, diff_gt_1_4_b, diff_gt_15_16_b, ld_stale_b;

  int     n_cmp = 0;
  int     n_err = 0;
  flags_t exp_q[$];

  always #5 clk = ~clk;

  steer_en_datapath #(.FAST_SIM(1'b1), .STALE_CYC(20'd100)) u_dut (
    .clk(clk), .rst(rst), .ld_vld(ld_vld), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .clr_tmr(clr_tmr), .tmr_full(tmr_full), .sum_gt_min(sum_gt_min),
    .sum_lt_min(sum_lt_min), .diff_gt_1_4(diff_gt_1_4),
    .diff_gt_15_16(diff_gt_15_16), .ld_stale(ld_stale)
  );

  steer_en_datapath #(.FAST_SIM(1'b1), .STALE_CYC(20'd100)) u_dut_b (
    .clk(clk), .rst(rst), .ld_vld(ld_vld), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .clr_tmr(clr_tmr_b), .tmr_full(tmr_full_b), .sum_gt_min(sum_gt_min_b),
    .sum_lt_min(sum_lt_min_b), .diff_gt_1_4(diff_gt_1_4_b),
    .diff_gt_15_16(diff_gt_15_16_b), .ld_stale(ld_stale_b)
  );

  // Reference model of the qualifier flags, in plain integer arithmetic.
  function automatic flags_t model(input int l, input int r);
    flags_t f;
    int s;
    int d;
    s = l + r;
    d = (l > r) ? (l - r) : (r - l);
    f.gt    = (s > 32'h240);
    f.lt    = (s < 32'h1C0);
    f.d14   = (d > (s / 4));
    f.d1516 = (d > (s - (s / 16)));
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic flags_t cur_flags();
    flags_t f;
    f.gt    = sum_gt_min;
    f.lt    = sum_lt_min;
    f.d14   = diff_gt_1_4;
    f.d1516 = diff_gt_15_16;
    return f;
  endfunction

  // Drive one sample; expected flags are queued now and checked two edges later.
  task automatic apply_sample(input logic [11:0] l, input logic [11:0] r, input string name);
    flags_t exp_f;
    flags_t act_f;
    exp_q.push_back(model(int'(l), int'(r)));
    lft_ld  = l;
    rght_ld = r;
    ld_vld  = 1'b1;
    step();
    ld_vld  = 1'b0;
    lft_ld  = 12'h000;
    rght_ld = 12'h000;
    step();
    exp_f = exp_q.pop_front();
    act_f = cur_flags();
    n_cmp++;
    if (act_f !== exp_f) begin
      n_err++;
      $display("FAIL %s: flags{gt,lt,d14,d1516} got %b want %b", name, act_f, exp_f);
    end
    n_cmp++;
    if (ld_stale !== 1'b0) begin
      n_err++;
      $display("FAIL %s_stale: ld_stale got %b want 0", name, ld_stale);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if ({tmr_full, sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, ld_stale} !== 6'b001000) begin
      n_err++;
      $display("FAIL %s: outs{full,gt,lt,d14,d1516,stale} got %b want 001000", name,
               {tmr_full, sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, ld_stale});
    end
    n_cmp++;
    if ({tmr_full_b, sum_gt_min_b, sum_lt_min_b, diff_gt_1_4_b, diff_gt_15_16_b, ld_stale_b} !== 6'b001000) begin
      n_err++;
      $display("FAIL %s_b: outs got %b want 001000", name,
               {tmr_full_b, sum_gt_min_b, sum_lt_min_b, diff_gt_1_4_b, diff_gt_15_16_b, ld_stale_b});
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    ld_vld    = 1'b0;
    lft_ld    = 12'h000;
    rght_ld   = 12'h000;
    clr_tmr   = 1'b0;
    clr_tmr_b = 1'b0;
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Timer reaches terminal count at edge 32768 after reset and holds; instance b is
  // cleared exactly on that edge and must stay low.
  task automatic test_timer_full();
    for (int k = 1; k <= 32767; k++) begin
      step();
      n_cmp++;
      if (tmr_full !== 1'b0) begin
        n_err++;
        $display("FAIL tmr_early: cycle %0d tmr_full got %b want 0", k, tmr_full);
      end
      if (k == 32767) clr_tmr_b = 1'b1;
    end
    step();
    clr_tmr_b = 1'b0;
    n_cmp++;
    if (tmr_full !== 1'b1) begin
      n_err++;
      $display("FAIL tmr_term: tmr_full got %b want 1", tmr_full);
    end
    n_cmp++;
    if (tmr_full_b !== 1'b0) begin
      n_err++;
      $display("FAIL tmr_clr_coincident: tmr_full_b got %b want 0", tmr_full_b);
    end
    for (int k = 0; k < 1000; k++) begin
      step();
      n_cmp++;
      if (tmr_full !== 1'b1 || tmr_full_b !== 1'b0) begin
        n_err++;
        $display("FAIL tmr_hold: cycle %0d full=%b full_b=%b want 1/0", k, tmr_full, tmr_full_b);
      end
    end
  endtask

  // One-cycle clear drops tmr_full next cycle; it returns 32768 edges later.
  task automatic test_timer_clr();
    clr_tmr = 1'b1;
    step();
    clr_tmr = 1'b0;
    n_cmp++;
    if (tmr_full !== 1'b0) begin
      n_err++;
      $display("FAIL tmr_clr: tmr_full got %b want 0", tmr_full);
    end
    for (int k = 1; k <= 32767; k++) begin
      step();
      n_cmp++;
      if (tmr_full !== 1'b0) begin
        n_err++;
        $display("FAIL tmr_reassert_early: cycle %0d tmr_full got %b want 0", k, tmr_full);
      end
    end
    step();
    n_cmp++;
    if (tmr_full !== 1'b1) begin
      n_err++;
      $display("FAIL tmr_reassert: tmr_full got %b want 1", tmr_full);
    end
  endtask

  task automatic test_sum_hysteresis();
    apply_sample(12'h150, 12'h150, "sum_2A0");
    apply_sample(12'h100, 12'h100, "sum_200_deadband");
    apply_sample(12'h0C0, 12'h0C0, "sum_180");
  endtask

  task automatic test_diff();
    apply_sample(12'h300, 12'h100, "diff_200");
    apply_sample(12'h3F0, 12'h010, "diff_3E0");
    apply_sample(12'h200, 12'h200, "diff_0");
    apply_sample(12'h280, 12'h180, "diff_100_eq_quarter");
    apply_sample(12'h010, 12'h3F0, "diff_swapped");
  endtask

  task automatic test_boundaries();
    apply_sample(12'h120, 12'h120, "sum_240");
    apply_sample(12'h121, 12'h120, "sum_241");
    apply_sample(12'h0E0, 12'h0E0, "sum_1C0");
    apply_sample(12'h0E0, 12'h0DF, "sum_1BF");
    apply_sample(12'hFFF, 12'hFFF, "sum_1FFE");
    apply_sample(12'hFFF, 12'h000, "diff_FFF");
  endtask

  // Heavy unbalanced rider, then silence: stale at 100 idle edges, flags forced next edge.
  task automatic test_stale();
    apply_sample(12'h3F0, 12'h010, "stale_pre");
    for (int k = 2; k <= 101; k++) begin
      step();
      if (k == 99) begin
        n_cmp++;
        if (ld_stale !== 1'b0) begin
          n_err++;
          $display("FAIL stale_early: ld_stale got %b want 0", ld_stale);
        end
      end else if (k == 100) begin
        n_cmp++;
        if (ld_stale !== 1'b1) begin
          n_err++;
          $display("FAIL stale_set: ld_stale got %b want 1", ld_stale);
        end
      end else if (k == 101) begin
        n_cmp++;
        if (cur_flags() !== 4'b0100 || ld_stale !== 1'b1) begin
          n_err++;
          $display("FAIL stale_forced: flags got %b stale %b want 0100 1", cur_flags(), ld_stale);
        end
      end
    end
    apply_sample(12'h3F0, 12'h010, "stale_restore");
  endtask

  // Asynchronous reset mid-cycle returns every output at once.
  task automatic test_reset_midrun();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_midrun");
    @(negedge clk);
    rst = 1'b0;
    step();
    check_reset_outputs("reset_release");
  endtask

  initial begin
    test_reset();
    test_timer_full();
    test_timer_clr();
    test_sum_hysteresis();
    test_diff();
    test_boundaries();
    test_stale();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
